toggle_gen: RTL
===============

TOGGLE_GEN -- requirements
Module: toggle_gen

Interface
REQ-001 The block SHALL have parameter WIDTH, default 8, giving the width of the period and burst fields.
REQ-002 The block SHALL have port clk, input, 1 bit: the single clock; all state changes on its rising edge.
REQ-003 The block SHALL have port rst, input, 1 bit: synchronous, active-high reset.
REQ-004 The block SHALL have port start, input, 1 bit: request to begin a run; sampled only in IDLE.
REQ-005 The block SHALL have port stop, input, 1 bit: abort request; takes priority over start and over completion.
REQ-006 The block SHALL have port period, input, WIDTH bits: cycles between toggle strobes; latched on accepted start.
REQ-007 The block SHALL have port burst, input, WIDTH bits: number of strobes per run; 0 means continuous; latched on accepted start.
REQ-008 The block SHALL have port t, output, 1 bit: registered one-cycle toggle strobe for the downstream toggle flip-flop.
REQ-009 The block SHALL have port busy, output, 1 bit: high while in RUN.
REQ-010 The block SHALL have port done, output, 1 bit: one-cycle pulse on normal burst completion.
REQ-011 The block SHALL have port cnt_left, output, WIDTH bits: strobes remaining in the current burst.

Function
REQ-012 The FSM SHALL have exactly two states: IDLE and RUN.
REQ-013 In IDLE, start=1 with stop=0 at an edge SHALL move the FSM to RUN and latch period, burst and cnt_left=burst.
REQ-014 A latched period of 0 SHALL be treated as 1.
REQ-015 t SHALL be high for exactly one cycle at edges k+P, k+2P, ..., where k is the edge at which start was accepted and P is the effective period.
REQ-016 t SHALL never be high in IDLE, and SHALL never be high for two consecutive cycles unless P=1.
REQ-017 In finite mode (burst>0), cnt_left SHALL decrement by 1 at each edge that raises t.
REQ-018 At the edge after the cycle in which the final strobe is high, the FSM SHALL return to IDLE with busy=0 and done=1 for one cycle.
REQ-019 In continuous mode (burst=0), the FSM SHALL strobe indefinitely, cnt_left SHALL hold 0, and done SHALL never assert.
REQ-020 The internal phase counter SHALL reload to P-1 on each strobe and SHALL not wrap or overflow for any P up to 2^WIDTH-1.
REQ-021 stop=1 in RUN SHALL return the FSM to IDLE at the next edge with t=0, cnt_left=0 and no done pulse, including when the final strobe is high in that same cycle.
REQ-022 start and stop both high in IDLE SHALL leave the FSM in IDLE.
REQ-023 start while in RUN SHALL be ignored, and period/burst changes during RUN SHALL have no effect.
REQ-024 In IDLE, start accepted in the same cycle that done is high SHALL begin a new run normally.

Reset
REQ-025 rst=1 at an edge SHALL force state=IDLE, t=0, busy=0, done=0, cnt_left=0 and phase=0, overriding start and stop.
REQ-026 Reset asserted during RUN SHALL abort the run with no done pulse and no further strobes.

Structure
REQ-027 The state enum (IDLE, RUN) and the default WIDTH constant SHALL reside in the shared package toggle_pkg.
REQ-028 The period phase counter (load, decrement, zero flag) SHALL be a sub-module named period_cnt; all other logic SHALL be in toggle_gen.
REQ-029 The bench SHALL drive the downstream toggle flip-flop from t, so that q toggles once per strobe.

Verification
REQ-030 period=3, burst=4, start at edge 0 -> t high at edges 3, 6, 9 and 12; cnt_left 4->3->2->1->0; done at edge 13; downstream q ends at its start value.
REQ-031 period=0, burst=3 -> t high for 3 consecutive cycles (edges 1-3); done at edge 4.
REQ-032 period=2, burst=0 -> t high at every 2nd edge for 20 cycles; stop at edge 11 -> t=0, busy=0 from edge 12; no done.
REQ-033 period=5, burst=2, rst raised at edge 4 -> busy=0 and cnt_left=0 at edge 5; no t or done afterwards.
REQ-034 start and stop both high in IDLE -> busy stays 0; start re-pulsed in RUN with different period -> strobe spacing unchanged.
REQ-035 stop raised in the cycle the final strobe is high (period=2, burst=1, stop at edge 2) -> IDLE at edge 3, done stays 0.

Source files
------------

// File: rtl/toggle_pkg.sv
// toggle_pkg: state encoding and default field width shared by toggle_gen and period_cnt
package toggle_pkg;
    localparam int WIDTH_DEFAULT = 8;
    typedef enum logic {IDLE, RUN} state_e;
endpackage

// File: rtl/period_cnt.sv
// period_cnt: phase down-counter with clear, load and decrement; flags when phase is zero
module period_cnt
    import toggle_pkg::*;
#(
    parameter int WIDTH = WIDTH_DEFAULT
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             clr_i,
    input  logic             load_i,
    input  logic             dec_i,
    input  logic [WIDTH-1:0] load_val_i,
    output logic             zero_o
);
    logic [WIDTH-1:0] phase_q, phase_d;
    // Saturates at zero so an unserviced decrement can never wrap.
    always_comb phase_d = clr_i ? '0 :
                          load_i ? load_val_i :
                          (dec_i && phase_q != '0) ? phase_q - 1'b1 : phase_q;
    always_ff @(posedge clk) begin
        if (rst) phase_q <= '0;
        else     phase_q <= phase_d;
    end
    assign zero_o = phase_q == '0;
endmodule

// File: rtl/toggle_gen.sv
// toggle_gen: emits one-cycle toggle strobes every period cycles, for a finite burst or continuously
module toggle_gen
    import toggle_pkg::*;
#(
    parameter int WIDTH = WIDTH_DEFAULT
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic             stop,
    input  logic [WIDTH-1:0] period,
    input  logic [WIDTH-1:0] burst,
    output logic             t,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] cnt_left
);
    state_e           state_q;
    logic             t_q, busy_q, done_q, cont_q, phase_zero;
    logic [WIDTH-1:0] cnt_q, pm1_q, pm1_d;
    logic             accept, last, run_go;
    assign accept = state_q == IDLE && start && !stop;
    // The cycle after the final strobe ends the run; stop outranks it.
    assign last   = t_q && !cont_q && cnt_q == '0;
    assign run_go = state_q == RUN && !stop && !last;
    assign pm1_d  = period == '0 ? '0 : period - 1'b1;
    period_cnt #(.WIDTH(WIDTH)) u_phase (
        .clk        (clk),
        .rst        (rst),
        .clr_i      (!accept && !run_go),
        .load_i     (accept || (run_go && phase_zero)),
        .dec_i      (run_go),
        .load_val_i (accept ? pm1_d : pm1_q),
        .zero_o     (phase_zero)
    );
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            t_q     <= 1'b0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
            cont_q  <= 1'b0;
            cnt_q   <= '0;
            pm1_q   <= '0;
        end else if (state_q == IDLE) begin
            t_q    <= 1'b0;
            done_q <= 1'b0;
            if (accept) begin
                state_q <= RUN;
                busy_q  <= 1'b1;
                pm1_q   <= pm1_d;
                cnt_q   <= burst;
                cont_q  <= burst == '0;
            end
        end else if (stop || last) begin
            state_q <= IDLE;
            busy_q  <= 1'b0;
            t_q     <= 1'b0;
            done_q  <= !stop;
            cnt_q   <= '0;
        end else begin
            t_q <= phase_zero;
            if (phase_zero && !cont_q) cnt_q <= cnt_q - 1'b1;
        end
    end
    assign t        = t_q;
    assign busy     = busy_q;
    assign done     = done_q;
    assign cnt_left = cnt_q;
endmodule
